// File: rtl/sys_ctrl_rx_if.sv
// Byte-in / register-and-ALU-command-out bundle of the
// system-controller receive decoder.
interface sys_ctrl_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);

  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  Wr_En;
  logic                  Rd_En;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] Wr_Data;
  logic                  ALU_EN;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  CLK_GATE_EN;
  logic                  Frame_Err;

  modport slave (
    input  RX_P_DATA,
    input  RX_D_VLD,
    output Wr_En,
    output Rd_En,
    output Address,
    output Wr_Data,
    output ALU_EN,
    output ALU_FUN,
    output CLK_GATE_EN,
    output Frame_Err
  );

  modport master (
    output RX_P_DATA,
    output RX_D_VLD,
    input  Wr_En,
    input  Rd_En,
    input  Address,
    input  Wr_Data,
    input  ALU_EN,
    input  ALU_FUN,
    input  CLK_GATE_EN,
    input  Frame_Err
  );

endinterface

// File: rtl/sys_ctrl_rx.sv
// Receive-side command-frame decoder: turns UART bytes into
// register-file write/read strobes and ALU start requests.
module sys_ctrl_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic          CLK,
  input  logic          rst,
  sys_ctrl_rx_if.slave  bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] OP_A    = 3'd4;
  localparam logic [2:0] OP_B    = 3'd5;
  localparam logic [2:0] ALU_FN  = 3'd6;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FN  = DATA_WIDTH'(8'hDD);

  logic [2:0]            state_q,   state_d;
  logic                  wr_en_q,   wr_en_d;
  logic                  rd_en_q,   rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  alu_en_q,  alu_en_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic                  cg_en_q,   cg_en_d;
  logic                  ferr_q,    ferr_d;

  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  rx_vld;

  assign rx_byte = bus.RX_P_DATA;
  assign rx_vld  = bus.RX_D_VLD;

  // Next-state and registered-output decode for one accepted byte
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    ferr_d    = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    cg_en_d   = cg_en_q;

    // Gate drops the cycle after the ALU start pulse; a new
    // ALU command accepted on that same edge re-arms it below.
    if (alu_en_q) begin
      cg_en_d = 1'b0;
    end

    if (rx_vld) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            (rx_byte == CMD_WR): begin
              state_d = WR_ADDR;
            end
            (rx_byte == CMD_RD): begin
              state_d = RD_ADDR;
            end
            (rx_byte == CMD_ALU): begin
              state_d = OP_A;
              cg_en_d = 1'b1;
            end
            (rx_byte == CMD_FN): begin
              state_d = ALU_FN;
              cg_en_d = 1'b1;
            end
            default: begin
              ferr_d = 1'b1;
            end
          endcase
        end
        WR_ADDR: begin
          addr_d  = rx_byte[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
        WR_DATA: begin
          wr_data_d = rx_byte;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
        RD_ADDR: begin
          addr_d  = rx_byte[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = IDLE;
        end
        OP_A: begin
          addr_d    = '0;
          wr_data_d = rx_byte;
          wr_en_d   = 1'b1;
          state_d   = OP_B;
        end
        OP_B: begin
          addr_d    = ADDR_WIDTH'(1);
          wr_data_d = rx_byte;
          wr_en_d   = 1'b1;
          state_d   = ALU_FN;
        end
        ALU_FN: begin
          alu_fun_d = rx_byte[FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset discards any partial frame
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      alu_en_q  <= 1'b0;
      alu_fun_q <= '0;
      cg_en_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      alu_en_q  <= alu_en_d;
      alu_fun_q <= alu_fun_d;
      cg_en_q   <= cg_en_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.Wr_En       = wr_en_q;
  assign bus.Rd_En       = rd_en_q;
  assign bus.Address     = addr_q;
  assign bus.Wr_Data     = wr_data_q;
  assign bus.ALU_EN      = alu_en_q;
  assign bus.ALU_FUN     = alu_fun_q;
  assign bus.CLK_GATE_EN = cg_en_q;
  assign bus.Frame_Err   = ferr_q;

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// Scoreboard bench for sys_ctrl_rx: expected strobes are queued
// as frames are driven and popped as the DUT pulses them.
module tb_sys_ctrl_rx;

  localparam logic [3:0] K_WR = 4'b1000;
  localparam logic [3:0] K_RD = 4'b0100;
  localparam logic [3:0] K_AL = 4'b0010;
  localparam logic [3:0] K_FE = 4'b0001;

  typedef struct {
    logic [3:0] kind;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] fun;
  } exp_t;

  logic CLK;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  sys_ctrl_rx_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) bus ();

  sys_ctrl_rx #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .FUN_WIDTH(4)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: every strobe cycle must match the oldest expectation
  always @(negedge CLK) begin
    logic [3:0] k;
    exp_t e;
    k = {bus.Wr_En, bus.Rd_En, bus.ALU_EN, bus.Frame_Err};
    if (!rst && k != 4'b0000) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got kind=%b addr=%h data=%h fun=%h, required no strobe",
                 k, bus.Address, bus.Wr_Data, bus.ALU_FUN);
      end else begin
        e = sb.pop_front();
        if (k !== e.kind ||
            ((e.kind == K_WR || e.kind == K_RD) && bus.Address !== e.addr) ||
            (e.kind == K_WR && bus.Wr_Data !== e.data) ||
            (e.kind == K_AL && bus.ALU_FUN !== e.fun)) begin
          n_fail++;
          $display("FAIL strobe: got kind=%b addr=%h data=%h fun=%h, required kind=%b addr=%h data=%h fun=%h",
                   k, bus.Address, bus.Wr_Data, bus.ALU_FUN,
                   e.kind, e.addr, e.data, e.fun);
        end
      end
    end
  end

  task automatic push(input logic [3:0] k, input logic [3:0] a,
                      input logic [7:0] d, input logic [3:0] f);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    e.fun  = f;
    sb.push_back(e);
  endtask

  // Drive one byte at a falling edge; it is accepted at the next rise
  task automatic send(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(negedge CLK);
  endtask

  task automatic gap(input int n);
    bus.RX_D_VLD = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 20;
    bus.RX_D_VLD = 1'b0;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending strobes, required 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if ({bus.Wr_En, bus.Rd_En, bus.ALU_EN, bus.Frame_Err,
         bus.CLK_GATE_EN} !== 5'b0 || bus.Address !== 4'h0 ||
        bus.Wr_Data !== 8'h00 || bus.ALU_FUN !== 4'h0) begin
      n_fail++;
      $display("FAIL %s: got en=%b%b%b%b cg=%b addr=%h data=%h fun=%h, required all 0",
               name, bus.Wr_En, bus.Rd_En, bus.ALU_EN, bus.Frame_Err,
               bus.CLK_GATE_EN, bus.Address, bus.Wr_Data, bus.ALU_FUN);
    end
  endtask

  task automatic check_cg(input string name, input logic exp);
    n_tests++;
    if (bus.CLK_GATE_EN !== exp) begin
      n_fail++;
      $display("FAIL %s: got CLK_GATE_EN=%b, required %b",
               name, bus.CLK_GATE_EN, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'h00;
    repeat (3) @(negedge CLK);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge CLK);
    send(8'hAA);
    send(8'h05);
    bus.RX_D_VLD = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("reset_midframe");
    @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    push(K_RD, 4'h3, 8'h00, 4'h0);
    send(8'hBB);
    send(8'h03);
    drain("reset_then_read");
  endtask

  task automatic test_write_b2b();
    push(K_WR, 4'h7, 8'h5A, 4'h0);
    send(8'hAA);
    send(8'h07);
    send(8'h5A);
    drain("write_b2b");
  endtask

  task automatic test_alu_gaps();
    push(K_WR, 4'h0, 8'h12, 4'h0);
    push(K_WR, 4'h1, 8'h34, 4'h0);
    push(K_AL, 4'h0, 8'h00, 4'h1);
    send(8'hCC);
    check_cg("cg_after_cmd", 1'b1);
    gap(2);
    check_cg("cg_gap1", 1'b1);
    send(8'h12);
    gap(2);
    send(8'h34);
    gap(3);
    check_cg("cg_gap2", 1'b1);
    send(8'h01);
    n_tests++;
    if (bus.ALU_EN !== 1'b1 || bus.CLK_GATE_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL cg_alu_cycle: got ALU_EN=%b CLK_GATE_EN=%b, required 1 1",
               bus.ALU_EN, bus.CLK_GATE_EN);
    end
    gap(1);
    check_cg("cg_cleared", 1'b0);
    drain("alu_gaps");
  endtask

  task automatic test_alu_trunc();
    push(K_AL, 4'h0, 8'h00, 4'h3);
    send(8'hDD);
    check_cg("cg_dd", 1'b1);
    send(8'hF3);
    gap(1);
    check_cg("cg_dd_cleared", 1'b0);
    drain("alu_trunc");
  endtask

  task automatic test_err_inner();
    push(K_FE, 4'h0, 8'h00, 4'h0);
    push(K_WR, 4'hB, 8'hAA, 4'h0);
    send(8'h55);
    gap(1);
    send(8'hAA);
    send(8'hBB);
    send(8'hAA);
    drain("err_inner");
  endtask

  task automatic test_stall();
    push(K_RD, 4'h2, 8'h00, 4'h0);
    send(8'hBB);
    gap(1000);
    n_tests++;
    if (sb.size() != 1) begin
      n_fail++;
      $display("FAIL stall_hold: got %0d pending, required 1", sb.size());
    end
    send(8'h02);
    drain("stall");
  endtask

  task automatic test_back_to_back();
    push(K_WR, 4'h0, 8'h11, 4'h0);
    push(K_WR, 4'h1, 8'h22, 4'h0);
    push(K_AL, 4'h0, 8'h00, 4'h5);
    push(K_WR, 4'h3, 8'h44, 4'h0);
    push(K_RD, 4'hC, 8'h00, 4'h0);
    send(8'hCC);
    send(8'h11);
    send(8'h22);
    send(8'hE5);
    send(8'hAA);
    send(8'h03);
    send(8'h44);
    send(8'hBB);
    send(8'hFC);
    drain("back_to_back");
    check_cg("cg_b2b_cleared", 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_write_b2b();
    test_alu_gaps();
    test_alu_trunc();
    test_err_inner();
    test_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_rx.md
# sys_ctrl_rx

Command-frame decoder on the receive side of the system controller. Consumes bytes delivered by the UART receiver, parses fixed-format command frames, and issues register-file write/read strobes and ALU operation requests. Its results (register read data, ALU result) return to the host through the system-controller transmit path and TX FIFO.

## Interface
- DATA_WIDTH, 8: width of a received byte, register data and operands.
- ADDR_WIDTH, 4: register-file address width; the address byte is truncated to its low ADDR_WIDTH bits.
- FUN_WIDTH, 4: ALU function code width; the function byte is truncated to its low FUN_WIDTH bits.

- CLK  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- RX_P_DATA  in  DATA_WIDTH  received byte; valid only when RX_D_VLD=1.
- RX_D_VLD  in  1  one-cycle pulse per received byte; may be high on consecutive cycles.
- Wr_En  out  1  register-file write strobe, one cycle wide.
- Rd_En  out  1  register-file read strobe, one cycle wide.
- Address  out  ADDR_WIDTH  register-file address; held until the next strobe.
- Wr_Data  out  DATA_WIDTH  register-file write data; held until the next write.
- ALU_EN  out  1  ALU start strobe, one cycle wide.
- ALU_FUN  out  FUN_WIDTH  ALU function code; held until the next ALU command.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- Frame_Err  out  1  one-cycle pulse when an unknown command byte arrives in IDLE.

## Operation
- A byte is accepted on a rising edge where RX_D_VLD=1. With RX_D_VLD=0, the FSM holds its state indefinitely; there is no timeout.
- Frames, first byte = command:
  - 0xAA: register write; bytes are address, then data.
  - 0xBB: register read; one byte, the address.
  - 0xCC: ALU with operands; bytes are operand A, operand B, then function.
  - 0xDD: ALU without operands; one byte, the function.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FN.
- Transitions on an accepted byte:
  - From IDLE: 0xAA goes to WR_ADDR, 0xBB to RD_ADDR, 0xCC to OP_A, 0xDD to ALU_FN. Any other value stays in IDLE and pulses Frame_Err.
  - WR_ADDR goes to WR_DATA.
  - OP_A goes to OP_B; OP_B goes to ALU_FN.
  - WR_DATA, RD_ADDR and ALU_FN return to IDLE.
- Actions on an accepted byte (all outputs registered):
  - WR_ADDR: latch Address; no strobe.
  - WR_DATA: Wr_Data ← byte; Wr_En=1.
  - RD_ADDR: Address ← byte; Rd_En=1.
  - OP_A: Address ← 0, Wr_Data ← byte, Wr_En=1. Operand A is stored at register 0.
  - OP_B: Address ← 1, Wr_Data ← byte, Wr_En=1. Operand B is stored at register 1.
  - ALU_FN: ALU_FUN ← byte[FUN_WIDTH-1:0]; ALU_EN=1.
- CLK_GATE_EN:
  - Set on the edge that accepts 0xCC or 0xDD.
  - Cleared on the edge after the ALU_EN pulse.
- Wr_En, Rd_En, ALU_EN and Frame_Err are mutually exclusive in any cycle.
- Command-byte values are not special inside a frame. For example, 0xAA received as a data byte is plain data.
- Reset, any time including mid-frame: state goes to IDLE and every output goes to 0. A partial frame is discarded with no strobe.

## Timing
- Latency: every strobe and data/address update is visible in the cycle after the edge that accepted the triggering byte, for exactly one cycle.
- Back-to-back bytes (RX_D_VLD high every cycle) are fully supported. For 0xCC frames this gives Wr_En high on two consecutive cycles (addresses 0 then 1), then ALU_EN in the following cycle.
- CLK_GATE_EN is high for at least one full cycle before ALU_EN and remains high during the ALU_EN cycle.
- Address, Wr_Data and ALU_FUN are stable while their strobe is high.

## Test plan
- Reset: assert rst mid-stream with 0xAA, 0x05 delivered. Required response: all outputs 0 and no Wr_En. A subsequent 0xBB, 0x03 gives Rd_En=1 for one cycle with Address=3.
- Register write, back-to-back: send 0xAA, 0x07, 0x5A on three consecutive cycles. Required response: one Wr_En cycle with Address=7, Wr_Data=0x5A, one cycle after the last byte.
- ALU with operands and gaps: send 0xCC, 0x12, 0x34, 0x01 with idle cycles between bytes. Required response:
  - Wr_En with Address 0 / Wr_Data 0x12, then Address 1 / Wr_Data 0x34.
  - Then ALU_EN with ALU_FUN=1.
  - CLK_GATE_EN high from the cycle after 0xCC through the ALU_EN cycle, low the next cycle.
- ALU without operands, truncation: send 0xDD, 0xF3. Required response: ALU_FUN=3, ALU_EN for one cycle, no Wr_En.
- Error and inner command bytes: send 0x55, then 0xAA, 0xBB, 0xAA. Required response: Frame_Err for one cycle after 0x55, then Wr_En with Address=0xB (0xBB truncated to ADDR_WIDTH) and Wr_Data=0xAA.
- Stall: send 0xBB, then hold RX_D_VLD low for 1000 cycles, then send 0x02. Required response: no strobes during the stall, then Rd_En with Address=2.
